wb_stage_regfile: RTL and testbench

//   Writeback end of the MEM/WB pipeline register: consumes its latched control/data, selects the writeback value,
//   and owns the 32x32 architectural register file. Provides two ID-stage read ports with same-cycle WB bypass.

---
 rtl/wb_stage_regfile_pkg.sv | 29 ++
 rtl/wb_stage_regfile_rf.sv | 35 +++
 rtl/wb_stage_regfile.sv | 115 +++++++++++
 tb/tb_wb_stage_regfile.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_regfile_pkg.sv
// Shared pipeline types and constants for the writeback stage.
// Also hosts the read-port bypass selector used by the register file.
package wb_stage_regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    WB_IDLE,
    WB_WAIT_LOAD
  } wb_state_t;

  function automatic logic [XLEN-1:0] bypass_sel(
    input logic [REG_ADDR_W-1:0] raddr,
    input logic                  we,
    input logic [REG_ADDR_W-1:0] waddr,
    input logic [XLEN-1:0]       wdata,
    input logic [XLEN-1:0]       rval
  );
    logic [XLEN-1:0] r;
    r = rval;
    if (raddr == REG_ZERO) r = '0;
    else if (we && raddr == waddr) r = wdata;
    return r;
  endfunction

endpackage

// File: rtl/wb_stage_regfile_rf.sv
// 32x32 register file: two read ports, one write port.
// Synchronous clear, r0 reads zero, same-cycle write bypass.
module regfile_2r1w
  import wb_stage_regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [XLEN-1:0]       wdata_i,
  input  logic [REG_ADDR_W-1:0] raddr_a_i,
  input  logic [REG_ADDR_W-1:0] raddr_b_i,
  output logic [XLEN-1:0]       rdata_a_o,
  output logic [XLEN-1:0]       rdata_b_o
);

  logic [XLEN-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_a_o = bypass_sel(raddr_a_i, we_i, waddr_i,
                           wdata_i, mem_q[raddr_a_i]);
    rdata_b_o = bypass_sel(raddr_b_i, we_i, waddr_i,
                           wdata_i, mem_q[raddr_b_i]);
  end

endmodule

// File: rtl/wb_stage_regfile.sv
// Writeback stage: selects the WB value, waits on late loads,
// commits to the register file and counts retired instructions.
module wb_stage_regfile
  import wb_stage_regfile_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 16,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_valid,
  input  logic                  reg_write,
  input  logic                  mem_to_reg,
  input  logic [REG_ADDR_W-1:0] dest_addr,
  input  logic [XLEN-1:0]       alu_result,
  input  logic [XLEN-1:0]       mem_rdata,
  input  logic                  mem_rvalid,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  output logic [XLEN-1:0]       rs_data,
  output logic [XLEN-1:0]       rt_data,
  output logic                  wb_stall,
  output logic                  fwd_en,
  output logic [REG_ADDR_W-1:0] fwd_addr,
  output logic [XLEN-1:0]       fwd_data,
  output logic                  load_err,
  output logic [CNT_W-1:0]      retired_count
);

  localparam int TW = $clog2(LOAD_TIMEOUT + 1);

  wb_state_t       state_q, state_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            err_q, err_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic            boot_q;

  logic [XLEN-1:0] wb_data;
  logic            data_ok;
  logic            abandon;
  logic            commit;
  logic            wr_en;

  // boot_q masks the first cycle after reset so stale MEM/WB
  // contents can neither stall nor commit.
  always_comb begin
    wb_data  = mem_to_reg ? mem_rdata : alu_result;
    data_ok  = !mem_to_reg || mem_rvalid;
    abandon  = !boot_q && state_q == WB_WAIT_LOAD && !mem_rvalid
               && tmo_q == TW'(LOAD_TIMEOUT);
    commit   = !boot_q && wb_valid && data_ok && !abandon;
    wr_en    = commit && reg_write && dest_addr != REG_ZERO;
    state_d  = state_q;
    tmo_d    = tmo_q;
    err_d    = err_q || abandon;
    ret_d    = ret_q + CNT_W'(commit);
    wb_stall = 1'b0;
    if (!boot_q) begin
      unique case (state_q)
        WB_IDLE: begin
          if (wb_valid && mem_to_reg && !mem_rvalid) begin
            state_d  = WB_WAIT_LOAD;
            tmo_d    = TW'(1);
            wb_stall = 1'b1;
          end
        end
        WB_WAIT_LOAD: begin
          if (mem_rvalid || abandon) begin
            state_d = WB_IDLE;
            tmo_d   = '0;
          end else begin
            tmo_d    = tmo_q + TW'(1);
            wb_stall = 1'b1;
          end
        end
        default: state_d = WB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= WB_IDLE;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      ret_q   <= '0;
      boot_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      ret_q   <= ret_d;
      boot_q  <= 1'b0;
    end
  end

  assign fwd_en        = wr_en;
  assign fwd_addr      = wr_en ? dest_addr : REG_ZERO;
  assign fwd_data      = wr_en ? wb_data : '0;
  assign load_err      = err_q;
  assign retired_count = ret_q;

  regfile_2r1w u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (wr_en),
    .waddr_i   (dest_addr),
    .wdata_i   (wb_data),
    .raddr_a_i (rs_addr),
    .raddr_b_i (rt_addr),
    .rdata_a_o (rs_data),
    .rdata_b_o (rt_data)
  );

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Randomized bench for wb_stage_regfile against an
// instruction-level reference model.
module tb_wb_stage_regfile;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic        reg_write = 1'b0;
  logic        mem_to_reg = 1'b0;
  logic [4:0]  dest_addr = '0;
  logic [31:0] alu_result = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic [31:0] rs_data, rt_data, fwd_data, retired_count;
  logic        wb_stall, fwd_en, load_err;
  logic [4:0]  fwd_addr;

  wb_stage_regfile #(.LOAD_TIMEOUT(T), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .dest_addr(dest_addr), .alu_result(alu_result),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .wb_stall(wb_stall), .fwd_en(fwd_en),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .load_err(load_err), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_rf [32];
  bit          m_err;
  logic [31:0] m_ret;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a,
                                         input bit we,
                                         input logic [4:0] d,
                                         input logic [31:0] v);
    if (a == 0) return 32'h0;
    if (we && a == d) return v;
    return m_rf[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_err = 0;
    m_ret = '0;
  endtask

  // One instruction: a load whose data shows up dly cycles late,
  // or is dropped when dly exceeds the timeout.
  task automatic run_instr(input bit v, input bit rw, input bit m2r,
                           input logic [4:0] d,
                           input logic [31:0] alu,
                           input logic [31:0] ld, input int dly,
                           input logic [4:0] ra,
                           input logic [4:0] rb);
    int ncyc;
    bit tmo, last, cm, we;
    logic [31:0] wd;
    tmo  = v && m2r && dly > T;
    ncyc = !(v && m2r) ? 1 : (tmo ? T + 1 : dly + 1);
    wd   = m2r ? ld : alu;
    for (int c = 0; c < ncyc; c++) begin
      last = (c == ncyc - 1);
      cm   = last && v && !tmo;
      we   = cm && rw && d != 0;
      @(negedge clk);
      wb_valid   = v;
      reg_write  = rw;
      mem_to_reg = m2r;
      dest_addr  = d;
      alu_result = alu;
      mem_rvalid = m2r ? (c >= dly) : 1'($urandom);
      mem_rdata  = (m2r && c >= dly) ? ld : $urandom;
      rs_addr    = ra;
      rt_addr    = rb;
      #1;
      check("stall", wb_stall, !last);
      check("fwd_en", fwd_en, we);
      check("fwd_addr", fwd_addr, we ? d : 5'd0);
      check("fwd_data", fwd_data, we ? wd : 32'h0);
      check("rs_data", rs_data, m_read(ra, we, d, wd));
      check("rt_data", rt_data, m_read(rb, we, d, wd));
      check("load_err", load_err, m_err);
      check("retired", retired_count, m_ret);
      if (we) m_rf[d] = wd;
      if (cm) m_ret++;
      if (tmo && last) m_err = 1;
    end
  endtask

  task automatic bubble(input logic [4:0] ra, input logic [4:0] rb);
    run_instr(0, 0, 0, 0, $urandom, $urandom, 0, ra, rb);
  endtask

  task automatic rand_instr();
    logic [4:0] d;
    d = 5'($urandom_range(0, 31));
    run_instr($urandom_range(0, 4) != 0, 1'($urandom),
              1'($urandom), d, $urandom, $urandom,
              $urandom_range(0, 6),
              $urandom_range(0, 1) ? d : 5'($urandom),
              $urandom_range(0, 2) == 0 ? d : 5'($urandom));
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bubble(5, 0);

    run_instr(1, 1, 0, 5, 32'hDEADBEEF, 0, 0, 5, 3);
    bubble(5, 5);
    check("t1_rs", rs_data, 32'hDEADBEEF);
    check("t1_ret", retired_count, 32'd1);

    run_instr(1, 1, 0, 7, 32'h12345678, 0, 0, 7, 7);
    run_instr(1, 1, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
    bubble(0, 7);
    check("t3_r0", rs_data, 32'h0);
    check("t3_ret", retired_count, 32'd3);

    run_instr(1, 1, 1, 9, $urandom, 32'hCAFE0001, 3, 9, 9);
    bubble(9, 0);
    check("t4_r9", rs_data, 32'hCAFE0001);
    check("t4_ret", retired_count, 32'd4);

    run_instr(1, 1, 1, 9, $urandom, 32'h0BAD0BAD, T + 3, 9, 1);
    bubble(9, 0);
    check("t5_err", load_err, 1'b1);
    check("t5_r9", rs_data, 32'hCAFE0001);
    check("t5_ret", retired_count, 32'd4);

    run_instr(1, 1, 1, 9, $urandom, 32'h5555AAAA, T, 9, 2);

    for (int i = 0; i < 400; i++) rand_instr();

    @(negedge clk);
    wb_valid   = 1'b1;
    reg_write  = 1'b1;
    mem_to_reg = 1'b1;
    dest_addr  = 5'd9;
    mem_rvalid = 1'b0;
    rs_addr    = 5'd9;
    rt_addr    = 5'd5;
    #1 check("t6_stall0", wb_stall, 1'b1);
    @(negedge clk);
    #1 check("t6_stall1", wb_stall, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    #1;
    check("t6_stall", wb_stall, 1'b0);
    check("t6_fwd", fwd_en, 1'b0);
    check("t6_err", load_err, 1'b0);
    check("t6_ret", retired_count, 32'd0);
    check("t6_rs", rs_data, 32'h0);
    check("t6_rt", rt_data, 32'h0);
    bubble(7, 5);

    for (int i = 0; i < 100; i++) rand_instr();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
